// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory handshake bundle: controller (master) to instruction/data memories (slave).
interface multicycle_ctrl_fsm_if;
    logic im_req;
    logic im_ack;
    logic dm_req;
    logic dm_we;
    logic dm_ack;

    modport master (
        output im_req,
        output dm_req,
        output dm_we,
        input  im_ack,
        input  dm_ack
    );

    modport slave (
        input  im_req,
        input  dm_req,
        input  dm_we,
        output im_ack,
        output dm_ack
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM for the 19-bit CPU.
// Optional perf counters enabled by defining CU_PERF_CNT_EN.
module multicycle_ctrl_fsm #(
    parameter int OPCODE_W = 5,
    parameter int ALU_MODE_W = 3,
    parameter logic [ALU_MODE_W-1:0] ADD_MODE = '0
`ifdef CU_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  br_cond,
    multicycle_ctrl_fsm_if.master mem,
    output logic                  load_ir,
    output logic                  inc_pc,
    output logic                  load_pc,
    output logic                  rf_we,
    output logic                  sel_a,
    output logic                  sel_b,
    output logic [ALU_MODE_W-1:0] alu_mode,
    output logic                  halted,
    output logic [2:0]            state
`ifdef CU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      retired_cnt,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ALU_MODE_W-1:0] alu_mode_q;
    logic [ALU_MODE_W-1:0] mode_d;
    logic                  legal;

    logic [1:0] op_class;
    logic       is_alu;
    logic       is_ldst;
    logic       is_br;
    logic       is_sys;
    logic       is_store;
    logic       op_ones;

    assign op_class = opcode[OPCODE_W-1 -: 2];
    assign is_alu   = op_class == 2'b00;
    assign is_ldst  = op_class == 2'b01;
    assign is_br    = op_class == 2'b10;
    assign is_sys   = op_class == 2'b11;
    assign is_store = opcode[0];
    assign op_ones  = &opcode;
    assign state    = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RESET;
            alu_mode_q <= '0;
        end else begin
            state_q    <= state_d;
            alu_mode_q <= mode_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = alu_mode_q;
        legal      = 1'b1;
        load_ir    = 1'b0;
        inc_pc     = 1'b0;
        load_pc    = 1'b0;
        rf_we      = 1'b0;
        sel_a      = 1'b0;
        sel_b      = 1'b0;
        halted     = 1'b0;
        mem.im_req = 1'b0;
        mem.dm_req = 1'b0;
        mem.dm_we  = 1'b0;
        unique case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem.im_req = 1'b1;
                if (mem.im_ack) begin
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // A takes PC for branches; B takes the immediate for LD/ST and BR
                sel_a = is_br;
                sel_b = is_ldst | is_br;
                unique case (1'b1)
                    is_sys:  state_d = op_ones ? S_HALT : S_FETCH;
                    default: state_d = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                unique case (1'b1)
                    is_alu: begin
                        mode_d  = opcode[ALU_MODE_W-1:0];
                        state_d = S_WB;
                    end
                    is_ldst: begin
                        mode_d  = ADD_MODE;
                        state_d = S_MEM;
                    end
                    is_br: begin
                        load_pc = br_cond;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem.dm_req = 1'b1;
                mem.dm_we  = is_store;
                if (mem.dm_ack) begin
                    state_d = is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: begin
                legal   = 1'b0;
                state_d = S_RESET;
            end
        endcase
        alu_mode = mode_d;
        // Freeze keeps requests up but drops strobes and any ack-driven move
        if (!en && legal) begin
            state_d = state_q;
            mode_d  = alu_mode_q;
            load_ir = 1'b0;
            inc_pc  = 1'b0;
            load_pc = 1'b0;
            rf_we   = 1'b0;
        end
    end

`ifdef CU_PERF_CNT_EN
    logic retire;
    logic stall;
    logic waiting;

    always_comb begin
        waiting = (state_q == S_FETCH) || (state_q == S_MEM);
        stall   = 1'b0;
        if (waiting) begin
            if (!en) begin
                stall = 1'b1;
            end else if (state_q == S_FETCH) begin
                stall = !mem.im_ack;
            end else begin
                stall = !mem.dm_ack;
            end
        end
        retire = en && (state_d == S_FETCH) &&
                 (state_q inside {S_DECODE, S_EXECUTE, S_MEM, S_WB});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (retire && !(&retired_cnt)) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
            if (stall && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: per-cycle expected trace built from instruction latency rules.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [4:0] opcode = '0;
    logic       br_cond = 1'b0;
    logic       load_ir;
    logic       inc_pc;
    logic       load_pc;
    logic       rf_we;
    logic       sel_a;
    logic       sel_b;
    logic [2:0] alu_mode;
    logic       halted;
    logic [2:0] state;
`ifdef CU_PERF_CNT_EN
    logic [15:0] retired_cnt;
    logic [15:0] stall_cnt;
`endif

    multicycle_ctrl_fsm_if mif();

    multicycle_ctrl_fsm dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .opcode(opcode),
        .br_cond(br_cond),
        .mem(mif),
        .load_ir(load_ir),
        .inc_pc(inc_pc),
        .load_pc(load_pc),
        .rf_we(rf_we),
        .sel_a(sel_a),
        .sel_b(sel_b),
        .alu_mode(alu_mode),
        .halted(halted),
        .state(state)
`ifdef CU_PERF_CNT_EN
        ,
        .retired_cnt(retired_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        im_ack;
        logic        dm_ack;
        logic        br_cond;
        logic [4:0]  opcode;
        logic [2:0]  st;
        logic        im_req;
        logic        dm_req;
        logic        dm_we;
        logic        load_ir;
        logic        inc_pc;
        logic        load_pc;
        logic        rf_we;
        logic        sel_a;
        logic        sel_b;
        logic        halted;
        logic [2:0]  mode;
        logic [15:0] ret;
        logic [15:0] stl;
    } cyc_t;

    cyc_t        q[$];
    logic [2:0]  m_mode = '0;
    logic [15:0] m_ret = '0;
    logic [15:0] m_stl = '0;
    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    logic [15:0] got;

    assign got = {state, mif.im_req, mif.dm_req, mif.dm_we, load_ir, inc_pc,
                  load_pc, rf_we, sel_a, sel_b, halted, alu_mode};

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c = '0;
        c.en = 1'b1;
        c.st = st;
        c.mode = m_mode;
        c.ret = m_ret;
        c.stl = m_stl;
        return c;
    endfunction

    function automatic logic [15:0] exp_vec(input cyc_t c);
        return {c.st, c.im_req, c.dm_req, c.dm_we, c.load_ir, c.inc_pc,
                c.load_pc, c.rf_we, c.sel_a, c.sel_b, c.halted, c.mode};
    endfunction

    task automatic push(input cyc_t c, input bit retire);
        q.push_back(c);
        if ((c.st == 3'd1 && (!c.en || !c.im_ack)) ||
            (c.st == 3'd4 && (!c.en || !c.dm_ack))) m_stl++;
        if (retire && c.en) m_ret++;
    endtask

    task automatic add_instr(input logic [4:0] op, input int iw, input int dw,
                             input logic brc, input int frz, input logic stray);
        cyc_t c;
        logic [1:0] cl;
        cl = op[4:3];
        for (int i = 0; i <= iw; i++) begin
            c = blank(3'd1);
            c.opcode = ~op;
            c.im_req = 1'b1;
            c.dm_ack = stray;
            if (i == iw) begin
                c.im_ack = 1'b1;
                c.load_ir = 1'b1;
                c.inc_pc = 1'b1;
            end
            push(c, 1'b0);
        end
        c = blank(3'd2);
        c.opcode = op;
        c.im_ack = stray;
        c.dm_ack = stray;
        c.sel_a = (cl == 2'd2);
        c.sel_b = (cl == 2'd1) || (cl == 2'd2);
        if (cl == 2'd3) begin
            push(c, op != 5'b11111);
            return;
        end
        push(c, 1'b0);
        c = blank(3'd3);
        c.opcode = op;
        c.im_ack = stray;
        c.dm_ack = stray;
        c.br_cond = brc;
        if (cl == 2'd0) m_mode = op[2:0];
        if (cl == 2'd1) m_mode = 3'd0;
        c.mode = m_mode;
        c.load_pc = (cl == 2'd2) && brc;
        push(c, cl == 2'd2);
        if (cl == 2'd2) return;
        if (cl == 2'd1) begin
            for (int i = 0; i < frz; i++) begin
                c = blank(3'd4);
                c.en = 1'b0;
                c.opcode = op;
                c.dm_req = 1'b1;
                c.dm_we = op[0];
                c.dm_ack = 1'b1;
                push(c, 1'b0);
            end
            for (int i = 0; i <= dw; i++) begin
                c = blank(3'd4);
                c.opcode = op;
                c.dm_req = 1'b1;
                c.dm_we = op[0];
                c.im_ack = stray;
                c.dm_ack = (i == dw);
                push(c, (i == dw) && op[0]);
            end
            if (op[0]) return;
        end
        c = blank(3'd5);
        c.opcode = op;
        c.rf_we = 1'b1;
        push(c, 1'b1);
    endtask

    task automatic add_halt(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = blank(3'd6);
            c.en = i[1];
            c.opcode = 5'b11111;
            c.im_ack = 1'b1;
            c.dm_ack = 1'b1;
            c.halted = 1'b1;
            push(c, 1'b0);
        end
    endtask

    task automatic add_reset(input logic e);
        cyc_t c;
        c = blank(3'd0);
        c.en = e;
        push(c, 1'b0);
    endtask

    function automatic int cnt(input int a, input int b, input int f);
        int n;
        n = 0;
        for (int i = a; i < b; i++) begin
            case (f)
                0: n += int'(q[i].dm_req);
                1: n += int'(q[i].rf_we);
                2: n += int'(q[i].dm_we);
                3: n += int'(q[i].load_pc);
                default: n += int'(q[i].halted);
            endcase
        end
        return n;
    endfunction

    task automatic pin(input string name, input int g, input int e);
        checks++;
        if (g != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, g, e);
        end
    endtask

    task automatic lit(input string name, input logic [15:0] e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, e);
        end
`ifdef CU_PERF_CNT_EN
        if (e == 16'h0) begin
            checks++;
            if (retired_cnt !== 16'h0 || stall_cnt !== 16'h0) begin
                errors++;
                $display("FAIL %s counters: got %0d/%0d expected 0/0",
                         name, retired_cnt, stall_cnt);
            end
        end
`endif
    endtask

    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            en = c.en;
            opcode = c.opcode;
            br_cond = c.br_cond;
            mif.im_ack = c.im_ack;
            mif.dm_ack = c.dm_ack;
            #2;
            checks++;
            if (got !== exp_vec(c)) begin
                errors++;
                $display("FAIL cycle %0d outputs: got %b expected %b",
                         ncyc, got, exp_vec(c));
            end
`ifdef CU_PERF_CNT_EN
            checks++;
            if (retired_cnt !== c.ret || stall_cnt !== c.stl) begin
                errors++;
                $display("FAIL cycle %0d counters: got %0d/%0d expected %0d/%0d",
                         ncyc, retired_cnt, stall_cnt, c.ret, c.stl);
            end
`endif
            ncyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s_ld, s_st, s_bt, s_bn, s_h, s_end;
        mif.im_ack = 1'b0;
        mif.dm_ack = 1'b0;
        #1 rst = 1'b1;
        #1 lit("reset state", 16'h0);
        @(negedge clk);
        rst = 1'b0;
        en = 1'b0;

        add_reset(1'b0);
        add_reset(1'b1);
        add_instr(5'b00011, 0, 0, 1'b0, 0, 1'b0);
        s_ld = q.size();
        add_instr(5'b01000, 1, 3, 1'b0, 0, 1'b1);
        s_st = q.size();
        add_instr(5'b01001, 0, 1, 1'b0, 0, 1'b0);
        s_bt = q.size();
        add_instr(5'b10000, 0, 0, 1'b1, 0, 1'b1);
        s_bn = q.size();
        add_instr(5'b10000, 1, 0, 1'b0, 0, 1'b0);
        add_instr(5'b11010, 0, 0, 1'b0, 0, 1'b1);
        add_instr(5'b00110, 2, 0, 1'b0, 0, 1'b0);
        add_instr(5'b01010, 0, 0, 1'b0, 5, 1'b0);
        add_instr(5'b10111, 0, 0, 1'b1, 0, 1'b0);
        s_h = q.size();
        add_instr(5'b11111, 0, 0, 1'b0, 0, 1'b0);
        add_halt(20);
        s_end = q.size();

        pin("alu cycle1 load_ir", int'(q[2].load_ir), 1);
        pin("alu cycle1 inc_pc", int'(q[2].inc_pc), 1);
        pin("alu cycle3 mode", int'(q[4].mode), 3);
        pin("alu cycle4 rf_we", int'(q[5].rf_we), 1);
        pin("alu cycle5 state", int'(q[6].st), 1);
        pin("load dm_req cycles", cnt(s_ld, s_st, 0), 4);
        pin("load rf_we pulses", cnt(s_ld, s_st, 1), 1);
        pin("load dm_we cycles", cnt(s_ld, s_st, 2), 0);
        pin("store dm_we cycles", cnt(s_st, s_bt, 2), 2);
        pin("store rf_we pulses", cnt(s_st, s_bt, 1), 0);
        pin("branch taken load_pc", cnt(s_bt, s_bn, 3), 1);
        pin("branch not taken load_pc", cnt(s_bn, s_bn + 4, 3), 0);
        pin("halt cycles", cnt(s_h, s_end, 4), 20);

        run_q();

        #1 rst = 1'b1;
        #1 lit("reset from halt", 16'h0);
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        mif.im_ack = 1'b0;
        mif.dm_ack = 1'b0;
        @(negedge clk);
        #1 lit("fetch before reset", 16'b001_1000000000_000);
        #2 rst = 1'b1;
        #1 lit("async reset mid-fetch", 16'h0);
        @(negedge clk);
        rst = 1'b0;
        en = 1'b0;

        m_mode = '0;
        m_ret = '0;
        m_stl = '0;
        add_reset(1'b1);
        add_instr(5'b00101, 1, 0, 1'b0, 0, 1'b1);
        add_instr(5'b11000, 0, 0, 1'b0, 0, 1'b0);
        run_q();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
